logic_unit_arbiter: RTL

Sequenced, shared 32-bit bitwise logic unit (AND/OR/XOR/NOR) that serves several requesters through valid/ready handshakes. Arbitration is round-robin. It sits beside the ALU in the processor datapath, where coprocessor, address-mask and debug paths each need occasional bitwise operations. Each transaction is accepted, computed into a result register, then held until the consumer takes it.

---
 rtl/logic_unit_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Shared bitwise logic unit (AND/OR/XOR/NOR) serving NUM_REQ requesters with
// round-robin arbitration: a grant in IDLE, a compute cycle in EXEC, then the result is held in RESP.
//   state | meaning
//   IDLE  | search for a valid requester from rr_ptr and grant it combinationally
//   EXEC  | apply the latched op to the latched operands and register the result
//   RESP  | hold resp_valid/result/id until the consumer takes it
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [WIDTH*NUM_REQ-1:0]   req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_result,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  int               scan;

  // Rotating priority search starting at rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!gnt_found && req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(scan);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      result_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      result_q     <= result_d;
      resp_id_q    <= resp_id_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    id_d      = id_q;
    result_d  = result_q;
    resp_id_d = resp_id_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          a_d      = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
          b_d      = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
          op_d     = req_op[2*int'(gnt_idx) +: 2];
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          2'b00:   result_d = a_q & b_q;
          2'b01:   result_d = a_q | b_q;
          2'b10:   result_d = a_q ^ b_q;
          default: result_d = ~(a_q | b_q);
        endcase
        resp_id_d = id_q;
        state_d   = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    resp_valid_d = (state_d == RESP);
    busy_d       = (state_d != IDLE);
  end

  // req_ready is the only combinational output; forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (reset_n && state_q == IDLE && gnt_found)
      req_ready = NUM_REQ'(1) << gnt_idx;
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_id     = resp_id_q;
  assign busy        = busy_q;

endmodule
